mt_pingpong_scheduler: RTL and testbench

- Sequences the softproc write-master template so that a continuous 32-bit sample stream is stored in SDRAM as fixed-size blocks.
- Blocks alternate between two buffers (ping-pong), so the Nios reads one buffer while the other fills.
- Drives the master's control/user ports and reports completed blocks to the fabric and to software.
- Sits in the FPGA top level between the crate-data capture path and the softproc instance.

---
 rtl/mt_sched_pkg.sv | 19 +
 rtl/mt_sat_counter.sv | 33 +++
 rtl/mt_pingpong_scheduler.sv | 153 +++++++++++++++
 tb/tb_mt_pingpong_scheduler.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_sched_pkg.sv
// Shared types and helpers for the ping-pong block scheduler.
package mt_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StStream,
    StWaitDone
  } sched_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic logic [31:0] buf_base(input logic        idx,
                                           input logic [31:0] base_a,
                                           input logic [31:0] base_b);
    return idx ? base_b : base_a;
  endfunction

endpackage

// File: rtl/mt_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment loads 1.
module mt_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? Width'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mt_pingpong_scheduler.sv
// Streams fixed-size sample blocks into two alternating SDRAM buffers via the write master.
// Optional MT_PINGPONG_OVERRUN_COUNT_EN adds a saturating dropped-word counter output.
module mt_pingpong_scheduler
  import mt_sched_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 512,
  parameter logic [31:0] BUF_A_BASE  = 32'h0000_0000,
  parameter logic [31:0] BUF_B_BASE  = 32'h0010_0000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             enable,
  input  logic             src_valid,
  input  logic [31:0]      src_data,
  output logic             src_ready,
  output logic             mt_fixed_location,
  output logic [31:0]      mt_write_base,
  output logic [31:0]      mt_write_length,
  output logic             mt_go,
  input  logic             mt_done,
  output logic             mt_write_buffer,
  output logic [31:0]      mt_buffer_data,
  input  logic             mt_buffer_full,
  output logic             blk_ready,
  output logic             blk_index,
  output logic [CNT_W-1:0] blk_count,
  output logic             overrun,
  input  logic             clear_overrun
`ifdef MT_PINGPONG_OVERRUN_COUNT_EN
  ,
  output logic [CNT_W-1:0] overrun_count
`endif
);

  localparam logic [31:0] BlockBytes = 32'(BLOCK_WORDS * BYTES_PER_WORD);
  localparam logic [15:0] LastWord   = 16'(BLOCK_WORDS - 1);

  sched_state_e     state_q;
  logic             cur_buf_q;
  logic             done_seen_q;
  logic             go_q;
  logic             blk_ready_q;
  logic             blk_index_q;
  logic             overrun_q;
  logic [15:0]      word_cnt_q;
  logic [31:0]      base_q;
  logic [31:0]      length_q;
  logic [CNT_W-1:0] blk_count_q;

  logic in_stream;
  logic wr;
  logic drop;

  // The source cannot stall, so ready is a pure function of state and FIFO space.
  assign in_stream = (state_q == StStream);
  assign src_ready = in_stream & ~mt_buffer_full;
  assign wr        = src_valid & src_ready;
  assign drop      = src_valid & ~src_ready;

  assign mt_fixed_location = 1'b0;
  assign mt_write_buffer   = wr;
  assign mt_buffer_data    = in_stream ? src_data : '0;
  assign mt_go             = go_q;
  assign mt_write_base     = base_q;
  assign mt_write_length   = length_q;
  assign blk_ready         = blk_ready_q;
  assign blk_index         = blk_index_q;
  assign blk_count         = blk_count_q;
  assign overrun           = overrun_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      cur_buf_q   <= 1'b0;
      done_seen_q <= 1'b0;
      go_q        <= 1'b0;
      blk_ready_q <= 1'b0;
      blk_index_q <= 1'b0;
      overrun_q   <= 1'b0;
      word_cnt_q  <= '0;
      base_q      <= '0;
      length_q    <= '0;
      blk_count_q <= '0;
    end else begin
      go_q        <= 1'b0;
      blk_ready_q <= 1'b0;
      // Done idles high, so only a low seen after ARM proves this block's transfer ran.
      if (state_q != StArm && !mt_done) begin
        done_seen_q <= 1'b1;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q  <= StArm;
            go_q     <= 1'b1;
            base_q   <= buf_base(cur_buf_q, BUF_A_BASE, BUF_B_BASE);
            length_q <= BlockBytes;
          end
        end
        StArm: begin
          state_q     <= StStream;
          done_seen_q <= 1'b0;
        end
        StStream: begin
          if (wr) begin
            if (word_cnt_q == LastWord) begin
              word_cnt_q <= '0;
              state_q    <= StWaitDone;
            end else begin
              word_cnt_q <= word_cnt_q + 16'd1;
            end
          end
        end
        StWaitDone: begin
          if (mt_done && done_seen_q) begin
            blk_ready_q <= 1'b1;
            blk_index_q <= cur_buf_q;
            blk_count_q <= blk_count_q + 1'b1;
            cur_buf_q   <= ~cur_buf_q;
            if (enable) begin
              state_q  <= StArm;
              go_q     <= 1'b1;
              base_q   <= buf_base(~cur_buf_q, BUF_A_BASE, BUF_B_BASE);
              length_q <= BlockBytes;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MT_PINGPONG_OVERRUN_COUNT_EN
  mt_sat_counter #(
    .Width(CNT_W)
  ) u_overrun_cnt (
    .clk_i  (clk_clk),
    .rst_ni (reset_reset_n),
    .inc_i  (drop),
    .clr_i  (clear_overrun),
    .count_o(overrun_count)
  );
`endif

endmodule

// File: tb/tb_mt_pingpong_scheduler.sv
// Self-checking bench for mt_pingpong_scheduler with a behavioural write-master model.
module tb_mt_pingpong_scheduler;

  localparam int unsigned BW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, src_valid, mt_done, mt_buffer_full, clear_overrun;
  logic [31:0] src_data = 32'h1000_0000;
  logic        src_ready, mt_fixed_location, mt_go, mt_write_buffer;
  logic [31:0] mt_write_base, mt_write_length, mt_buffer_data;
  logic        blk_ready, blk_index, overrun;
  logic [15:0] blk_count;
`ifdef MT_PINGPONG_OVERRUN_COUNT_EN
  logic [15:0] overrun_count;
`endif

  logic       c4_inc, c4_clr;
  logic [3:0] c4_count;

  int checks = 0;
  int errors = 0;
  int go_cnt, blk_seen, wr_total;

  logic [31:0] base_q[$];
  logic        idx_q[$];
  logic [31:0] mon_base;
  logic        mon_idx;

  bit   auto_done;
  logic man_done, m_done;
  int   m_wr, m_dly;

  always #5 clk = ~clk;
  always @(posedge clk) #1 src_data = src_data + 32'd1;

  mt_pingpong_scheduler #(
    .BLOCK_WORDS(BW),
    .BUF_A_BASE (32'h0000_0000),
    .BUF_B_BASE (32'h0010_0000),
    .CNT_W      (16)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .enable           (enable),
    .src_valid        (src_valid),
    .src_data         (src_data),
    .src_ready        (src_ready),
    .mt_fixed_location(mt_fixed_location),
    .mt_write_base    (mt_write_base),
    .mt_write_length  (mt_write_length),
    .mt_go            (mt_go),
    .mt_done          (mt_done),
    .mt_write_buffer  (mt_write_buffer),
    .mt_buffer_data   (mt_buffer_data),
    .mt_buffer_full   (mt_buffer_full),
    .blk_ready        (blk_ready),
    .blk_index        (blk_index),
    .blk_count        (blk_count),
    .overrun          (overrun),
    .clear_overrun    (clear_overrun)
`ifdef MT_PINGPONG_OVERRUN_COUNT_EN
    ,
    .overrun_count    (overrun_count)
`endif
  );

  mt_sat_counter #(
    .Width(4)
  ) u_cnt4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (c4_inc),
    .clr_i  (c4_clr),
    .count_o(c4_count)
  );

  // Master model: done drops the cycle after go, rises 3 cycles after the 4th write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b1;
      m_wr   <= 0;
      m_dly  <= 0;
    end else if (auto_done) begin
      if (mt_go) begin
        m_done <= 1'b0;
        m_wr   <= 0;
      end else if (mt_write_buffer) begin
        if (m_wr == BW - 1) m_dly <= 3;
        m_wr <= m_wr + 1;
      end else if (m_dly != 0) begin
        m_dly <= m_dly - 1;
        if (m_dly == 1) m_done <= 1'b1;
      end
    end
  end
  assign mt_done = auto_done ? m_done : man_done;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mt_go) begin
        go_cnt++;
        checks++;
        if (base_q.size() == 0) begin
          errors++;
          $display("FAIL go_base: unexpected go, base %h, no go expected", mt_write_base);
        end else begin
          mon_base = base_q.pop_front();
          if (mt_write_base !== mon_base || mt_write_length !== BW * 4) begin
            errors++;
            $display("FAIL go_base: base %h len %0d, expected base %h len %0d",
                     mt_write_base, mt_write_length, mon_base, BW * 4);
          end
        end
      end
      if (blk_ready) begin
        blk_seen++;
        checks++;
        if (idx_q.size() == 0) begin
          errors++;
          $display("FAIL blk_index: unexpected blk_ready, index %0d", blk_index);
        end else begin
          mon_idx = idx_q.pop_front();
          if (blk_index !== mon_idx) begin
            errors++;
            $display("FAIL blk_index: got %0d expected %0d", blk_index, mon_idx);
          end
        end
      end
      if (mt_write_buffer) begin
        wr_total++;
        checks++;
        if (mt_buffer_data !== src_data) begin
          errors++;
          $display("FAIL fwd_data: got %h expected %h", mt_buffer_data, src_data);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    enable         = 1'b0;
    src_valid      = 1'b0;
    mt_buffer_full = 1'b0;
    clear_overrun  = 1'b0;
    man_done       = 1'b1;
    c4_inc         = 1'b0;
    c4_clr         = 1'b0;
    base_q.delete();
    idx_q.delete();
    cyc(2);
    go_cnt   = 0;
    blk_seen = 0;
    wr_total = 0;
    rst_n    = 1'b1;
  endtask

  task automatic wait_blk(input int target, input string name);
    int n = 0;
    while (blk_seen < target && n < 200) begin
      cyc(1);
      n++;
    end
    checks++;
    if (blk_seen < target) begin
      errors++;
      $display("FAIL %s: blk_ready count %0d, needed %0d (timeout)", name, blk_seen, target);
    end
  endtask

  task automatic wait_wr(input int target, input string name);
    int n = 0;
    while (wr_total < target && n < 200) begin
      cyc(1);
      n++;
    end
    checks++;
    if (wr_total < target) begin
      errors++;
      $display("FAIL %s: writes %0d, needed %0d (timeout)", name, wr_total, target);
    end
  endtask

  task automatic wait_go(input string name);
    int n = 0;
    while (go_cnt < 1 && n < 50) begin
      cyc(1);
      n++;
    end
    checks++;
    if (go_cnt < 1) begin
      errors++;
      $display("FAIL %s: no go seen (timeout)", name);
    end
  endtask

  task automatic test_reset();
    auto_done = 1'b1;
    do_reset();
    rst_n     = 1'b0;
    src_valid = 1'b1;
    #1;
    checks++;
    if ({src_ready, mt_fixed_location, mt_write_base, mt_write_length, mt_go, mt_write_buffer,
         mt_buffer_data, blk_ready, blk_index, blk_count, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready %b base %h len %h go %b wb %b data %h cnt %h ovr %b",
               src_ready, mt_write_base, mt_write_length, mt_go, mt_write_buffer,
               mt_buffer_data, blk_count, overrun);
    end
    src_valid = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    checks++;
    if (go_cnt !== 0 || src_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: go count %0d ready %b, expected 0 and 0", go_cnt, src_ready);
    end
  endtask

  task automatic test_pingpong();
    auto_done = 1'b1;
    do_reset();
    base_q.push_back(32'h0000_0000);
    base_q.push_back(32'h0010_0000);
    idx_q.push_back(1'b0);
    idx_q.push_back(1'b1);
    enable    = 1'b1;
    src_valid = 1'b1;
    wait_blk(1, "pp_blk1");
    enable = 1'b0;
    wait_blk(2, "pp_blk2");
    src_valid = 1'b0;
    cyc(6);
    checks++;
    if (blk_count !== 16'd2 || wr_total !== 2 * BW || blk_index !== 1'b1) begin
      errors++;
      $display("FAIL pp_totals: count %0d writes %0d index %0d, expected 2 %0d 1",
               blk_count, wr_total, blk_index, 2 * BW);
    end
    checks++;
    if (go_cnt !== 2 || base_q.size() != 0 || idx_q.size() != 0) begin
      errors++;
      $display("FAIL pp_gos: go count %0d, pending bases %0d, expected 2 and 0",
               go_cnt, base_q.size());
    end
  endtask

  task automatic test_buffer_full();
    auto_done = 1'b1;
    do_reset();
    base_q.push_back(32'h0000_0000);
    idx_q.push_back(1'b0);
    enable = 1'b1;
    wait_go("bf_go");
    enable    = 1'b0;
    src_valid = 1'b1;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bf_ovr_pre: overrun %b expected 0", overrun);
    end
    wait_wr(2, "bf_wr2");
    mt_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (src_ready !== 1'b0 || mt_write_buffer !== 1'b0) begin
        errors++;
        $display("FAIL bf_ready: cycle %0d ready %b write %b, expected 0 0",
                 i, src_ready, mt_write_buffer);
      end
      cyc(1);
    end
    mt_buffer_full = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bf_ovr: overrun %b expected 1", overrun);
    end
    wait_wr(BW, "bf_wr4");
    src_valid = 1'b0;
    wait_blk(1, "bf_blk");
    cyc(3);
    checks++;
    if (wr_total !== BW) begin
      errors++;
      $display("FAIL bf_writes: writes %0d expected %0d", wr_total, BW);
    end
    clear_overrun = 1'b1;
    cyc(1);
    clear_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: overrun %b expected 0", overrun);
    end
    clear_overrun = 1'b1;
    src_valid     = 1'b1;
    cyc(1);
    clear_overrun = 1'b0;
    src_valid     = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop_wins: overrun %b expected 1", overrun);
    end
  endtask

  task automatic test_stale_done();
    auto_done = 1'b0;
    do_reset();
    base_q.push_back(32'h0000_0000);
    idx_q.push_back(1'b0);
    enable = 1'b1;
    wait_go("sd_go");
    enable    = 1'b0;
    src_valid = 1'b1;
    wait_wr(BW, "sd_wr");
    src_valid = 1'b0;
    cyc(5);
    checks++;
    if (blk_seen !== 0) begin
      errors++;
      $display("FAIL stale_done: blk_ready count %0d before done low, expected 0", blk_seen);
    end
    man_done = 1'b0;
    cyc(1);
    man_done = 1'b1;
    wait_blk(1, "sd_blk");
    cyc(5);
    checks++;
    if (blk_seen !== 1 || go_cnt !== 1 || blk_count !== 16'd1) begin
      errors++;
      $display("FAIL sd_single: blk_ready %0d go %0d count %0d, expected 1 1 1",
               blk_seen, go_cnt, blk_count);
    end
  endtask

  task automatic test_enable_drop();
    auto_done = 1'b1;
    do_reset();
    base_q.push_back(32'h0000_0000);
    idx_q.push_back(1'b0);
    enable    = 1'b1;
    src_valid = 1'b1;
    wait_wr(2, "ed_wr2");
    enable = 1'b0;
    wait_blk(1, "ed_blk");
    src_valid = 1'b0;
    cyc(8);
    checks++;
    if (wr_total !== BW || go_cnt !== 1 || src_ready !== 1'b0 || blk_count !== 16'd1) begin
      errors++;
      $display("FAIL ed_idle: writes %0d go %0d ready %b count %0d, expected %0d 1 0 1",
               wr_total, go_cnt, src_ready, blk_count, BW);
    end
  endtask

  task automatic test_async_reset();
    auto_done = 1'b1;
    do_reset();
    base_q.push_back(32'h0000_0000);
    enable    = 1'b1;
    src_valid = 1'b1;
    wait_wr(2, "ar_wr2");
    rst_n = 1'b0;
    #1;
    checks++;
    if ({src_ready, mt_write_base, mt_write_length, mt_go, mt_write_buffer, mt_buffer_data,
         blk_ready, blk_index, blk_count, overrun} !== '0) begin
      errors++;
      $display("FAIL ar_outputs: ready %b base %h len %h go %b wb %b data %h ovr %b",
               src_ready, mt_write_base, mt_write_length, mt_go, mt_write_buffer,
               mt_buffer_data, overrun);
    end
    base_q.delete();
    idx_q.delete();
    cyc(1);
    go_cnt   = 0;
    blk_seen = 0;
    wr_total = 0;
    base_q.push_back(32'h0000_0000);
    idx_q.push_back(1'b0);
    rst_n = 1'b1;
    wait_go("ar_go");
    enable = 1'b0;
    wait_blk(1, "ar_blk");
    src_valid = 1'b0;
    cyc(2);
    checks++;
    if (wr_total !== BW || blk_count !== 16'd1) begin
      errors++;
      $display("FAIL ar_restart: writes %0d count %0d, expected %0d 1",
               wr_total, blk_count, BW);
    end
  endtask

`ifdef MT_PINGPONG_OVERRUN_COUNT_EN
  task automatic test_overrun_count();
    do_reset();
    src_valid = 1'b1;
    cyc(5);
    src_valid = 1'b0;
    checks++;
    if (overrun_count !== 16'd5) begin
      errors++;
      $display("FAIL ovr_count5: got %0d expected 5", overrun_count);
    end
    src_valid     = 1'b1;
    clear_overrun = 1'b1;
    cyc(1);
    src_valid     = 1'b0;
    clear_overrun = 1'b0;
    checks++;
    if (overrun_count !== 16'd1) begin
      errors++;
      $display("FAIL ovr_count_clr: got %0d expected 1", overrun_count);
    end
  endtask
`endif

  task automatic test_sat_counter();
    do_reset();
    c4_inc = 1'b1;
    cyc(20);
    c4_inc = 1'b0;
    checks++;
    if (c4_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_count: got %0d expected 15", c4_count);
    end
    c4_inc = 1'b1;
    c4_clr = 1'b1;
    cyc(1);
    c4_inc = 1'b0;
    checks++;
    if (c4_count !== 4'd1) begin
      errors++;
      $display("FAIL sat_clr_inc: got %0d expected 1", c4_count);
    end
    cyc(1);
    c4_clr = 1'b0;
    checks++;
    if (c4_count !== 4'd0) begin
      errors++;
      $display("FAIL sat_clr: got %0d expected 0", c4_count);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    src_valid      = 1'b0;
    mt_buffer_full = 1'b0;
    clear_overrun  = 1'b0;
    man_done       = 1'b1;
    auto_done      = 1'b1;
    c4_inc         = 1'b0;
    c4_clr         = 1'b0;
    go_cnt         = 0;
    blk_seen       = 0;
    wr_total       = 0;
    test_reset();
    test_pingpong();
    test_buffer_full();
    test_stale_done();
    test_enable_drop();
    test_async_reset();
`ifdef MT_PINGPONG_OVERRUN_COUNT_EN
    test_overrun_count();
`endif
    test_sat_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
